// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: request, ALU and response bundle around the ALU issue controller
interface alu_issue_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 5
);
    logic              req0_valid_i, req0_ready_o;
    logic [DATA_W-1:0] req0_rs1_i, req0_rs2_i;
    logic [OP_W-1:0]   req0_op_i;
    logic              req1_valid_i, req1_ready_o;
    logic [DATA_W-1:0] req1_rs1_i, req1_rs2_i;
    logic [OP_W-1:0]   req1_op_i;
    logic [DATA_W-1:0] alu_rs1_o, alu_rs2_o, alu_rd_i;
    logic [OP_W-1:0]   alu_op_o;
    logic              rsp0_valid_o, rsp0_ready_i, rsp1_valid_o, rsp1_ready_i;
    logic [DATA_W-1:0] rsp_rd_o;
    logic              busy_o;
    logic [15:0]       done_cnt_o;

    modport slave (
        input  req0_valid_i, req0_rs1_i, req0_rs2_i, req0_op_i,
        input  req1_valid_i, req1_rs1_i, req1_rs2_i, req1_op_i,
        input  alu_rd_i, rsp0_ready_i, rsp1_ready_i,
        output req0_ready_o, req1_ready_o, alu_rs1_o, alu_rs2_o, alu_op_o,
        output rsp0_valid_o, rsp1_valid_o, rsp_rd_o, busy_o, done_cnt_o
    );

    modport master (
        output req0_valid_i, req0_rs1_i, req0_rs2_i, req0_op_i,
        output req1_valid_i, req1_rs1_i, req1_rs2_i, req1_op_i,
        output alu_rd_i, rsp0_ready_i, rsp1_ready_i,
        input  req0_ready_o, req1_ready_o, alu_rs1_o, alu_rs2_o, alu_op_o,
        input  rsp0_valid_o, rsp1_valid_o, rsp_rd_o, busy_o, done_cnt_o
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: round-robin two-requester issue controller for a registered ALU
module alu_issue_ctrl #(
    parameter int DATA_W  = 32,
    parameter int OP_W    = 5,
    parameter int ALU_LAT = 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    alu_issue_ctrl_if.slave  bus
);
    localparam int CW = $clog2(ALU_LAT + 1);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t        state, state_nxt;
    logic          last_grant, gnt_id, gnt, hs, take;
    logic [CW-1:0] cnt;
    logic [15:0]   done_cnt;

    always_comb begin
        gnt              = (bus.req0_valid_i && bus.req1_valid_i) ? ~last_grant : bus.req1_valid_i;
        hs               = (state == IDLE) && (bus.req0_valid_i || bus.req1_valid_i);
        take             = (state == RESP) && (gnt_id ? bus.rsp1_ready_i : bus.rsp0_ready_i);
        bus.req0_ready_o = hs && !gnt;
        bus.req1_ready_o = hs && gnt;
        bus.rsp0_valid_o = (state == RESP) && !gnt_id;
        bus.rsp1_valid_o = (state == RESP) && gnt_id;
        bus.busy_o       = state != IDLE;
        bus.done_cnt_o   = done_cnt;
        state_nxt        = hs ? EXEC : (state == EXEC && cnt == '0) ? RESP : take ? IDLE : state;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state         <= IDLE;
            last_grant    <= 1'b1;
            gnt_id        <= 1'b0;
            cnt           <= '0;
            done_cnt      <= '0;
            bus.alu_rs1_o <= '0;
            bus.alu_rs2_o <= '0;
            bus.alu_op_o  <= '0;
            bus.rsp_rd_o  <= '0;
        end else begin
            state    <= state_nxt;
            done_cnt <= done_cnt + 16'(take);
            if (hs) begin
                bus.alu_rs1_o <= gnt ? bus.req1_rs1_i : bus.req0_rs1_i;
                bus.alu_rs2_o <= gnt ? bus.req1_rs2_i : bus.req0_rs2_i;
                bus.alu_op_o  <= gnt ? bus.req1_op_i : bus.req0_op_i;
                gnt_id        <= gnt;
                last_grant    <= gnt;
                cnt           <= CW'(ALU_LAT);
            end else if (cnt != '0) begin
                cnt <= cnt - CW'(1);
            end
            // the ALU result lines up with the last EXEC cycle
            if (state == EXEC && cnt == '0) bus.rsp_rd_o <= bus.alu_rd_i;
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: vector, corner-case and randomized scoreboard checks of alu_issue_ctrl
module tb_alu_issue_ctrl;
    localparam int LAT_A = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          passed = 0;
    int          total = 0;
    logic [15:0] exp_done = '0;

    always #5 clk = ~clk;

    alu_issue_ctrl_if #(.DATA_W(32), .OP_W(5)) ia ();
    alu_issue_ctrl_if #(.DATA_W(32), .OP_W(5)) ib ();

    alu_issue_ctrl #(.DATA_W(32), .OP_W(5), .ALU_LAT(LAT_A)) dut_a (.clk_i(clk), .rst_n_i(rst_n), .bus(ia.slave));
    alu_issue_ctrl #(.DATA_W(32), .OP_W(5), .ALU_LAT(4))     dut_b (.clk_i(clk), .rst_n_i(rst_n), .bus(ib.slave));

    function automatic logic [31:0] alu_f(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        return op == 5'd1 ? a + b : op == 5'd3 ? a ^ b : op == 5'd4 ? a - b : 32'd0;
    endfunction

    logic [31:0] pa;
    logic [31:0] pb [4];
    always @(posedge clk) begin
        pa    <= alu_f(ia.alu_op_o, ia.alu_rs1_o, ia.alu_rs2_o);
        pb[0] <= alu_f(ib.alu_op_o, ib.alu_rs1_o, ib.alu_rs2_o);
        for (int i = 1; i < 4; i++) pb[i] <= pb[i-1];
    end
    assign ia.alu_rd_i = pa;
    assign ib.alu_rd_i = pb[3];

    typedef struct {
        bit          id;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [4:0]  op;
        logic [31:0] rd;
    } vec_t;
    vec_t tbl [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input bit id, input logic v, input logic [31:0] r1, input logic [31:0] r2, input logic [4:0] op);
        if (id) begin
            ia.req1_valid_i = v; ia.req1_rs1_i = r1; ia.req1_rs2_i = r2; ia.req1_op_i = op;
        end else begin
            ia.req0_valid_i = v; ia.req0_rs1_i = r1; ia.req0_rs2_i = r2; ia.req0_op_i = op;
        end
    endtask

    task automatic idle_all;
        set_a(1'b0, 1'b0, '0, '0, '0);
        set_a(1'b1, 1'b0, '0, '0, '0);
        ia.rsp0_ready_i = 1'b0; ia.rsp1_ready_i = 1'b0;
        ib.req0_valid_i = 1'b0; ib.req0_rs1_i = '0; ib.req0_rs2_i = '0; ib.req0_op_i = '0;
        ib.req1_valid_i = 1'b0; ib.req1_rs1_i = '0; ib.req1_rs2_i = '0; ib.req1_op_i = '0;
        ib.rsp0_ready_i = 1'b0; ib.rsp1_ready_i = 1'b0;
    endtask

    task automatic do_reset;
        idle_all();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        exp_done = '0;
    endtask

    task automatic do_op(input bit id, input logic [31:0] r1, input logic [31:0] r2, input logic [4:0] op, input logic [31:0] exp);
        set_a(id, 1'b1, r1, r2, op);
        #1;
        chk("op_ready", {ia.req1_ready_o, ia.req0_ready_o}, id ? 2 : 1);
        tick();
        set_a(id, 1'b0, '0, '0, '0);
        #1;
        chk("op_alu_rs1", ia.alu_rs1_o, r1);
        chk("op_alu_rs2", ia.alu_rs2_o, r2);
        chk("op_alu_op", ia.alu_op_o, op);
        chk("op_busy", ia.busy_o, 1);
        chk("op_exec1_valid", {ia.rsp1_valid_o, ia.rsp0_valid_o}, 0);
        tick();
        chk("op_exec2_valid", {ia.rsp1_valid_o, ia.rsp0_valid_o}, 0);
        tick();
        chk("op_rsp_valid", {ia.rsp1_valid_o, ia.rsp0_valid_o}, id ? 2 : 1);
        chk("op_rsp_rd", ia.rsp_rd_o, exp);
        if (id) ia.rsp1_ready_i = 1'b1; else ia.rsp0_ready_i = 1'b1;
        tick();
        ia.rsp0_ready_i = 1'b0; ia.rsp1_ready_i = 1'b0;
        exp_done++;
        #1;
        chk("op_done_cnt", ia.done_cnt_o, exp_done);
        chk("op_idle", ia.busy_o, 0);
    endtask

    initial begin
        bit          ng, mbusy, mlast, mid, hold0, hold1, v0, v1, g;
        int          lastc, nseen, macc, e;
        logic [31:0] mrd;

        tbl[0] = '{1'b0, 32'd5, 32'd7, 5'd1, 32'd12};
        tbl[1] = '{1'b1, 32'hFFFF_FFFF, 32'd1, 5'd1, 32'd0};
        tbl[2] = '{1'b0, 32'hFFFF_FFFF, 32'd1, 5'd2, 32'd0};
        tbl[3] = '{1'b1, 32'h0000_00F0, 32'h0000_000F, 5'd3, 32'h0000_00FF};
        tbl[4] = '{1'b0, 32'd1, 32'd2, 5'd4, 32'hFFFF_FFFF};
        tbl[5] = '{1'b1, 32'd100, 32'd23, 5'd1, 32'd123};
        tbl[6] = '{1'b0, 32'd0, 32'd0, 5'd1, 32'd0};

        idle_all();
        tick();
        tick();
        chk("rst_busy", ia.busy_o, 0);
        chk("rst_ready", {ia.req1_ready_o, ia.req0_ready_o}, 0);
        chk("rst_valid", {ia.rsp1_valid_o, ia.rsp0_valid_o}, 0);
        chk("rst_alu_rs1", ia.alu_rs1_o, 0);
        chk("rst_alu_op", ia.alu_op_o, 0);
        chk("rst_rsp_rd", ia.rsp_rd_o, 0);
        chk("rst_done", ia.done_cnt_o, 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) do_op(tbl[i].id, tbl[i].rs1, tbl[i].rs2, tbl[i].op, tbl[i].rd);

        // contention: both continuously valid, responses taken at once
        do_reset();
        set_a(1'b0, 1'b1, 32'd3, 32'd4, 5'd1);
        set_a(1'b1, 1'b1, 32'd10, 32'd20, 5'd1);
        ia.rsp0_ready_i = 1'b1; ia.rsp1_ready_i = 1'b1;
        ng = 1'b0; nseen = 0; lastc = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (ia.req0_ready_o || ia.req1_ready_o) begin
                chk("alt_grant", ia.req1_ready_o, ng);
                if (nseen > 0) chk("alt_interval", c - lastc, LAT_A + 3);
                ng = ~ng; lastc = c; nseen++;
            end
            if (ia.rsp0_valid_o) begin chk("alt_rd0", ia.rsp_rd_o, 7); exp_done++; end
            if (ia.rsp1_valid_o) begin chk("alt_rd1", ia.rsp_rd_o, 30); exp_done++; end
            tick();
        end
        idle_all();
        chk("alt_grants", nseen, 5);
        chk("alt_done", ia.done_cnt_o, exp_done);

        // backpressure on rsp0 with req1 waiting
        set_a(1'b0, 1'b1, 32'd5, 32'd7, 5'd1);
        #1;
        chk("bp_ready0", ia.req0_ready_o, 1);
        tick();
        set_a(1'b0, 1'b0, '0, '0, '0);
        set_a(1'b1, 1'b1, 32'd10, 32'd20, 5'd1);
        for (int c = 1; c < 8; c++) begin
            #1;
            chk("bp_ready1", ia.req1_ready_o, 0);
            chk("bp_busy", ia.busy_o, 1);
            chk("bp_alu_rs1", ia.alu_rs1_o, 5);
            if (c >= 3) begin
                chk("bp_valid", {ia.rsp1_valid_o, ia.rsp0_valid_o}, 1);
                chk("bp_rd", ia.rsp_rd_o, 12);
            end
            tick();
        end
        ia.rsp0_ready_i = 1'b1;
        #1;
        chk("bp_hs_valid", ia.rsp0_valid_o, 1);
        chk("bp_hs_ready1", ia.req1_ready_o, 0);
        tick();
        ia.rsp0_ready_i = 1'b0;
        exp_done++;
        #1;
        chk("bp_accept1", ia.req1_ready_o, 1);
        chk("bp_done", ia.done_cnt_o, exp_done);
        tick();
        set_a(1'b1, 1'b0, '0, '0, '0);
        tick();
        tick();
        chk("bp_rsp1_valid", {ia.rsp1_valid_o, ia.rsp0_valid_o}, 2);
        chk("bp_rsp1_rd", ia.rsp_rd_o, 30);
        ia.rsp1_ready_i = 1'b1;
        tick();
        ia.rsp1_ready_i = 1'b0;
        exp_done++;

        // completion counter wrap
        force dut_a.done_cnt = 16'hFFFF;
        tick();
        release dut_a.done_cnt;
        exp_done = 16'hFFFF;
        chk("wrap_pre", ia.done_cnt_o, 16'hFFFF);
        do_op(1'b0, 32'd1, 32'd1, 5'd1, 32'd2);
        chk("wrap_zero", ia.done_cnt_o, 0);

        // reset during the second EXEC cycle
        set_a(1'b1, 1'b1, 32'd9, 32'd9, 5'd1);
        tick();
        set_a(1'b1, 1'b0, '0, '0, '0);
        tick();
        rst_n = 1'b0;
        tick();
        exp_done = '0;
        chk("mrst_busy", ia.busy_o, 0);
        chk("mrst_valid", {ia.rsp1_valid_o, ia.rsp0_valid_o}, 0);
        chk("mrst_ready", {ia.req1_ready_o, ia.req0_ready_o}, 0);
        chk("mrst_alu_op", ia.alu_op_o, 0);
        chk("mrst_done", ia.done_cnt_o, 0);
        rst_n = 1'b1;
        ia.rsp0_ready_i = 1'b1; ia.rsp1_ready_i = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("mrst_no_rsp", {ia.rsp1_valid_o, ia.rsp0_valid_o, ia.busy_o}, 0);
        end
        idle_all();

        // ALU_LAT=4 instance
        ib.req0_valid_i = 1'b1; ib.req0_rs1_i = 32'd1; ib.req0_rs2_i = 32'd2; ib.req0_op_i = 5'd1;
        #1;
        chk("lat4_ready", ib.req0_ready_o, 1);
        tick();
        ib.req0_valid_i = 1'b0;
        for (int c = 1; c < 6; c++) begin
            #1;
            chk("lat4_no_valid", {ib.rsp1_valid_o, ib.rsp0_valid_o}, 0);
            chk("lat4_no_capture", ib.rsp_rd_o, 0);
            tick();
        end
        #1;
        chk("lat4_valid", {ib.rsp1_valid_o, ib.rsp0_valid_o}, 1);
        chk("lat4_rd", ib.rsp_rd_o, 3);
        ib.rsp0_ready_i = 1'b1;
        tick();
        ib.rsp0_ready_i = 1'b0;
        chk("lat4_done", ib.done_cnt_o, 1);

        // randomized traffic against a transaction-level scoreboard
        do_reset();
        mbusy = 1'b0; mlast = 1'b1; mid = 1'b0; macc = 0; mrd = '0; hold0 = 1'b0; hold1 = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!hold0) set_a(1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom, 5'($urandom_range(1, 4)));
            if (!hold1) set_a(1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom, 5'($urandom_range(1, 4)));
            ia.rsp0_ready_i = 1'($urandom_range(0, 1));
            ia.rsp1_ready_i = 1'($urandom_range(0, 1));
            #1;
            v0 = ia.req0_valid_i; v1 = ia.req1_valid_i;
            if (!mbusy) begin
                g = (v0 && v1) ? !mlast : v1;
                e = (v0 || v1) ? (g ? 2 : 1) : 0;
                chk("rnd_grant", {ia.req1_ready_o, ia.req0_ready_o}, e);
                chk("rnd_idle_valid", {ia.rsp1_valid_o, ia.rsp0_valid_o}, 0);
                if (v0 || v1) begin
                    mbusy = 1'b1; mid = g; mlast = g; macc = cyc;
                    mrd = g ? alu_f(ia.req1_op_i, ia.req1_rs1_i, ia.req1_rs2_i)
                            : alu_f(ia.req0_op_i, ia.req0_rs1_i, ia.req0_rs2_i);
                end
            end else begin
                chk("rnd_no_ready", {ia.req1_ready_o, ia.req0_ready_o}, 0);
                e = (cyc >= macc + LAT_A + 2) ? (mid ? 2 : 1) : 0;
                chk("rnd_rsp_valid", {ia.rsp1_valid_o, ia.rsp0_valid_o}, e);
                if (e != 0 && (mid ? ia.rsp1_ready_i : ia.rsp0_ready_i)) begin
                    chk("rnd_rd", ia.rsp_rd_o, mrd);
                    chk("rnd_done", ia.done_cnt_o, exp_done);
                    exp_done++;
                    mbusy = 1'b0;
                end
            end
            hold0 = v0 && !ia.req0_ready_o;
            hold1 = v1 && !ia.req1_ready_o;
            tick();
        end
        idle_all();
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
